// File: rtl/cdp_rdma_eg_pkg.sv
// Shared definitions for the CDP RDMA egress interface: info-field layout and
// egress FSM encoding. Used by both the transmitter (pack) and receiver (unpack).
package cdp_rdma_eg_pkg;

    localparam int INFO_W    = 23;

    localparam int LANES_LSB = 0;
    localparam int LINE_END  = 8;
    localparam int SURF_END  = 9;
    localparam int CUBE_END  = 10;
    localparam int LAYER_END = 11;
    localparam int LAST_W    = 12;
    localparam int LAST_H    = 13;
    localparam int LAST_C    = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } eg_state_t;

endpackage

// File: rtl/cdp_rdma_eg_pipe.sv
// Single-entry valid/ready register stage. The producer pushes with 'load' only
// when 'in_ready' is high, so a held beat is never overwritten.
module cdp_rdma_eg_pipe #(
    parameter int W = 8
) (
    input  logic         nvdla_core_clk,
    input  logic         nvdla_core_rstn,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    assign in_ready = ~out_valid | out_ready;

    // Valid flag: set on push, cleared when the held beat drains with no refill.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Payload register: only changes on a push, so it is stable while stalled.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            out_data <= '0;
        end else if (load) begin
            out_data <= load_data;
        end
    end

endmodule

// File: rtl/cdp_rdma_eg_pack.sv
// CDP RDMA egress packer: walks the cube (w, then h, then channel groups),
// tags each read-return beat with its 23-bit position/info field and forwards
// it through a one-deep output register. One layer per op_en rising edge.
// Optional stall performance counter: define CDP_RDMA_EG_PERF_EN.
//
//   state | meaning
//   IDLE  | waiting for op_en rising edge
//   RUN   | accepting and tagging input beats
//   FLUSH | final beat held in output register, waiting to drain
module cdp_rdma_eg_pack
    import cdp_rdma_eg_pkg::*;
#(
    parameter  int THROUGHPUT = 8,
    parameter  int BPE        = 8,
    localparam int DW         = THROUGHPUT * BPE
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rstn,
    input  logic                 reg2dp_op_en,
    input  logic [12:0]          reg2dp_width,
    input  logic [12:0]          reg2dp_height,
    input  logic [12:0]          reg2dp_channel,
    input  logic [DW-1:0]        rd_data_pd,
    input  logic                 rd_data_valid,
    output logic                 rd_data_ready,
    output logic [DW+INFO_W-1:0] cdp_rdma2dp_pd,
    output logic                 cdp_rdma2dp_valid,
    input  logic                 cdp_rdma2dp_ready,
    output logic                 eg_done,
    output logic [31:0]          dp2reg_eg_stall_cnt
);

    localparam int LB = $clog2(THROUGHPUT);
    localparam int GW = 13 - LB;

    eg_state_t          state, state_nxt;
    logic               op_en_d1;
    logic               op_en_load;
    logic               layer_start;
    logic               done_nxt;
    logic [12:0]        width_lat, height_lat, chan_lat;
    logic [12:0]        w_cnt, h_cnt;
    logic [GW-1:0]      c_cnt;
    logic               last_w, last_h, last_c;
    logic               load;
    logic               pipe_in_ready;
    logic [3:0]         lanes;
    logic [INFO_W-1:0]  info;

    assign op_en_load  = reg2dp_op_en & ~op_en_d1;
    assign layer_start = (state == IDLE) & op_en_load;

    assign last_w = (w_cnt == width_lat);
    assign last_h = (h_cnt == height_lat);
    assign last_c = (c_cnt == chan_lat[12:LB]);

    assign rd_data_ready = (state == RUN) & pipe_in_ready;
    assign load          = rd_data_valid & rd_data_ready;

    // Edge detect on the op_en level.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) op_en_d1 <= 1'b0;
        else                  op_en_d1 <= reg2dp_op_en;
    end

    // FSM state register plus registered done pulse.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state   <= IDLE;
            eg_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            eg_done <= done_nxt;
        end
    end

    // FSM next-state; op_en edges outside IDLE are deliberately ignored.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE:  if (op_en_load) state_nxt = RUN;
            RUN:   if (load & last_w & last_h & last_c) state_nxt = FLUSH;
            FLUSH: if (~cdp_rdma2dp_valid | cdp_rdma2dp_ready) begin
                       state_nxt = IDLE;
                       done_nxt  = 1'b1;
                   end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch cube bounds at layer start; advance w/h/c position per accepted beat.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            width_lat  <= '0;
            height_lat <= '0;
            chan_lat   <= '0;
            w_cnt      <= '0;
            h_cnt      <= '0;
            c_cnt      <= '0;
        end else if (layer_start) begin
            width_lat  <= reg2dp_width;
            height_lat <= reg2dp_height;
            chan_lat   <= reg2dp_channel;
            w_cnt      <= '0;
            h_cnt      <= '0;
            c_cnt      <= '0;
        end else if (load) begin
            if (last_w) begin
                w_cnt <= '0;
                if (last_h) begin
                    h_cnt <= '0;
                    if (!last_c) c_cnt <= c_cnt + GW'(1);
                end else begin
                    h_cnt <= h_cnt + 13'd1;
                end
            end else begin
                w_cnt <= w_cnt + 13'd1;
            end
        end
    end

    // Info field for the beat being accepted this cycle.
    always_comb begin
        lanes           = last_c ? 4'(chan_lat[LB-1:0]) : 4'(THROUGHPUT - 1);
        info            = '0;
        info[LANES_LSB +: 4] = lanes;
        info[LINE_END]  = last_w;
        info[SURF_END]  = last_w & last_h;
        info[CUBE_END]  = last_w & last_h & last_c;
        info[LAYER_END] = last_w & last_h & last_c;
        info[LAST_W]    = last_w;
        info[LAST_H]    = last_h;
        info[LAST_C]    = last_c;
    end

    cdp_rdma_eg_pipe #(
        .W (DW + INFO_W)
    ) u_pipe (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .load            (load),
        .load_data       ({info, rd_data_pd}),
        .out_ready       (cdp_rdma2dp_ready),
        .in_ready        (pipe_in_ready),
        .out_valid       (cdp_rdma2dp_valid),
        .out_data        (cdp_rdma2dp_pd)
    );

`ifdef CDP_RDMA_EG_PERF_EN
    logic [31:0] stall_cnt;

    // Saturating count of downstream-stalled cycles within the current layer.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            stall_cnt <= '0;
        end else if (layer_start) begin
            stall_cnt <= '0;
        end else if ((state != IDLE) && cdp_rdma2dp_valid && !cdp_rdma2dp_ready
                     && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign dp2reg_eg_stall_cnt = stall_cnt;
`else
    assign dp2reg_eg_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_cdp_rdma_eg_pack.sv
// Directed bench for cdp_rdma_eg_pack: walks several cube shapes, stalls the
// output, re-pulses op_en mid-layer and resets mid-layer.
module tb_cdp_rdma_eg_pack;
    import cdp_rdma_eg_pkg::*;

    localparam int DW = 64;
    localparam int PW = DW + INFO_W;
`ifdef CDP_RDMA_EG_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          op_en = 1'b0;
    logic [12:0]   width = '0, height = '0, channel = '0;
    logic [DW-1:0] rd_pd = '0;
    logic          rd_valid = 1'b0;
    logic          rd_ready;
    logic [PW-1:0] out_pd;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          done;
    logic [31:0]   stall_cnt;

    int n_vec = 0;
    int n_miscmp = 0;
    int layer_id = 0;
    logic [6:0] exp_hi    [0:15];
    logic [3:0] exp_lanes [0:15];

    always #5 clk = ~clk;

    cdp_rdma_eg_pack #(.THROUGHPUT(8), .BPE(8)) dut (
        .nvdla_core_clk      (clk),
        .nvdla_core_rstn     (rstn),
        .reg2dp_op_en        (op_en),
        .reg2dp_width        (width),
        .reg2dp_height       (height),
        .reg2dp_channel      (channel),
        .rd_data_pd          (rd_pd),
        .rd_data_valid       (rd_valid),
        .rd_data_ready       (rd_ready),
        .cdp_rdma2dp_pd      (out_pd),
        .cdp_rdma2dp_valid   (out_valid),
        .cdp_rdma2dp_ready   (out_ready),
        .eg_done             (done),
        .dp2reg_eg_stall_cnt (stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat(input int layer, input int idx);
        return {32'hA5A5_0000 + 32'(layer), 32'(idx)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // A new input beat must never be pushed while the output register is stalled.
    always @(negedge clk) begin
        if (rstn)
            assert (!(rd_valid && rd_ready && out_valid && !out_ready))
            else chk("no_load_on_stall", 1, 0);
    end

    task automatic run_layer(input logic [12:0] w, input logic [12:0] h, input logic [12:0] c,
                             input int n_exp, input int stall_at, input int stall_len,
                             input int repulse_at);
        int  cyc = 0, in_idx = 0, out_cnt = 0, done_cnt = 0, done_cyc = 0;
        int  last_hs_cyc = -10, stall_left = 0;
        bit  stall_done = 1'b0, in_hs, out_hs;
        layer_id++;
        width = w; height = h; channel = c;
        op_en = 1'b1;
        rd_valid = 1'b1;
        rd_pd = beat(layer_id, 0);
        out_ready = 1'b1;
        while (cyc < 400 && !(done_cnt > 0 && cyc >= done_cyc + 3)) begin
            @(negedge clk);
            in_hs  = rd_valid & rd_ready;
            out_hs = out_valid & out_ready;
            if (out_valid && !out_ready) begin
                chk("stall_rd_ready", rd_ready, 0);
                chk("stall_pd_data", out_pd[DW-1:0], beat(layer_id, out_cnt));
            end
            if (out_hs) begin
                chk("beat_data", out_pd[DW-1:0], beat(layer_id, out_cnt));
                if (out_cnt < n_exp) begin
                    chk("info_14_8", out_pd[DW+14 -: 7], exp_hi[out_cnt]);
                    chk("info_lanes", out_pd[DW+3 -: 4], exp_lanes[out_cnt]);
                    chk("info_zero", {out_pd[DW+22 -: 8], out_pd[DW+7 -: 4]}, 0);
                end else begin
                    chk("extra_beat", out_cnt, n_exp - 1);
                end
                out_cnt++;
                last_hs_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc = cyc;
                    chk("done_latency", cyc, last_hs_cyc + 1);
                    chk("done_beats", out_cnt, n_exp);
                end else begin
                    chk("done_once", done_cnt, 1);
                end
            end
            @(posedge clk);
            #1;
            if (in_hs) in_idx++;
            rd_valid = (in_idx < n_exp);
            rd_pd = beat(layer_id, in_idx);
            if (stall_left > 0) stall_left--;
            else if (stall_len > 0 && !stall_done && out_cnt == stall_at) begin
                stall_left = stall_len;
                stall_done = 1'b1;
            end
            out_ready = (stall_left == 0);
            if (repulse_at > 0 && cyc == repulse_at)     op_en = 1'b0;
            if (repulse_at > 0 && cyc == repulse_at + 1) op_en = 1'b1;
            cyc++;
        end
        chk("done_count", done_cnt, 1);
        chk("beats_out", out_cnt, n_exp);
        chk("beats_in", in_idx, n_exp);
        chk("stall_cnt", stall_cnt, PERF ? 32'(stall_len) : 32'd0);
        op_en = 1'b0;
        rd_valid = 1'b0;
        tick;
    endtask

    task automatic set_a(input logic [3:0] lanes_last);
        exp_hi[0] = 7'h20; exp_hi[1] = 7'h33; exp_hi[2] = 7'h60; exp_hi[3] = 7'h7F;
        exp_lanes[0] = 4'd7; exp_lanes[1] = 4'd7;
        exp_lanes[2] = lanes_last; exp_lanes[3] = lanes_last;
    endtask

    task automatic set_c;
        for (int i = 0; i < 8; i++) exp_lanes[i] = 4'd7;
        exp_hi[0] = 7'h40; exp_hi[1] = 7'h40; exp_hi[2] = 7'h40; exp_hi[3] = 7'h51;
        exp_hi[4] = 7'h60; exp_hi[5] = 7'h60; exp_hi[6] = 7'h60; exp_hi[7] = 7'h7F;
    endtask

    initial begin
        #2 rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_pd", out_pd[63:0], 0);
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        tick;
        rstn = 1'b1;
        tick;

        // w=1 h=0 c=15: two groups, full lanes throughout.
        set_a(4'd7);
        run_layer(13'd1, 13'd0, 13'd15, 4, 0, 0, 0);

        // Degenerate single-element cube.
        exp_hi[0] = 7'h7F; exp_lanes[0] = 4'd0;
        run_layer(13'd0, 13'd0, 13'd0, 1, 0, 0, 0);

        // 4x2x8 cube with a 5-cycle downstream stall mid-layer.
        set_c;
        run_layer(13'd3, 13'd1, 13'd7, 8, 3, 5, 0);

        // Partial last channel group: 3 lanes valid.
        set_a(4'd2);
        run_layer(13'd1, 13'd0, 13'd10, 4, 0, 0, 0);

        // Second op_en edge during RUN is ignored; next layer starts fresh.
        set_c;
        run_layer(13'd3, 13'd1, 13'd7, 8, 0, 0, 3);
        set_a(4'd7);
        run_layer(13'd1, 13'd0, 13'd15, 4, 0, 0, 0);

        // Reset in the middle of a layer.
        width = 13'd3; height = 13'd1; channel = 13'd7;
        op_en = 1'b1;
        rd_valid = 1'b1;
        rd_pd = beat(99, 0);
        out_ready = 1'b1;
        repeat (4) tick;
        chk("pre_rst_valid", out_valid, 1);
        rstn = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_rd_ready", rd_ready, 0);
        chk("midrst_state", dut.state, IDLE);
        chk("midrst_done", done, 0);
        op_en = 1'b0;
        rd_valid = 1'b0;
        tick;
        tick;
        rstn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("postrst_no_done", done, 0);
        end
        tick;
        set_c;
        run_layer(13'd3, 13'd1, 13'd7, 8, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
